// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
// Used by pipe_skid_stage and its optional perf counters (PIPE_SKID_PERF_EN).
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [31:0] RV_NOP     = 32'h0000_0013;
   localparam int          PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with synchronous clear and count enable.
// Instantiated by pipe_skid_stage when PIPE_SKID_PERF_EN is defined.
module pipe_perf_cnt
   import pipe_pkg::*;
#(
   parameter int W = PERF_CNT_W
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready stage register with 2-entry skid buffer and flush.
// Define PIPE_SKID_PERF_EN to add stall/bubble/flush counters.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(RV_NOP),
   parameter bit                FLUSH_CLR  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_cnt,
   output logic [PERF_CNT_W-1:0] bubble_cnt,
   output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_fire, out_fire;

   // Handshake outputs come from registered state only.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = out_valid ? main_q : BUBBLE_VAL;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         if (FLUSH_CLR) begin
            main_d = BUBBLE_VAL;
            skid_d = BUBBLE_VAL;
         end
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE_VAL;
         skid_q  <= BUBBLE_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef PIPE_SKID_PERF_EN
   pipe_perf_cnt #(.W(PERF_CNT_W)) u_stall (
      .clk (clk),
      .clr (rst),
      .en  (out_valid & ~out_ready),
      .cnt (stall_cnt)
   );

   pipe_perf_cnt #(.W(PERF_CNT_W)) u_bubble (
      .clk (clk),
      .clr (rst),
      .en  (~out_valid),
      .cnt (bubble_cnt)
   );

   pipe_perf_cnt #(.W(PERF_CNT_W)) u_flush (
      .clk (clk),
      .clr (rst),
      .en  (flush),
      .cnt (flush_cnt)
   );
`endif

endmodule
